// File: rtl/bos_pkg.sv
// Shared constants and types for the bos host byte-stream path.
package bos_pkg;

   localparam int unsigned LEN_W      = 8;
   localparam int unsigned BUF_DEPTH  = 1 << LEN_W;
   localparam logic [7:0]  BOS_PREFIX = 8'hDD;
   localparam int unsigned BOS_N_DEST = 18;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SRC,
      ST_DEST,
      ST_LEN,
      ST_DATA,
      ST_CRC
   } rx_state_e;

   typedef struct packed {
      logic [7:0]       src;
      logic [7:0]       dest;
      logic [LEN_W-1:0] len;
   } pkt_hdr_t;

endpackage

// File: rtl/pkt_buf.sv
// Payload buffer: simple dual-port RAM, synchronous write, registered read.
module pkt_buf
   import bos_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [LEN_W-1:0] wr_addr,
   input  logic [7:0]       wr_data,
   input  logic             rd_en,
   input  logic [LEN_W-1:0] rd_addr,
   output logic [7:0]       rd_data
);

   logic [7:0] mem [BUF_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register is reset so the routed data bus is clean out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/rx_packet_router.sv
// Parses framed bytes from the host UART, checks them and routes payloads one-hot.
module rx_packet_router
   import bos_pkg::*;
#(
   parameter int unsigned N_DEST  = BOS_N_DEST,
   parameter logic [7:0]  PREFIX  = BOS_PREFIX,
   parameter int unsigned TIMEOUT = 100000
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        master_data,
   output logic [N_DEST-1:0] valid_bus,
   output logic [7:0]        src_addr,
   output logic              pkt_ok,
   output logic              err_crc,
   output logic              err_addr,
   output logic              err_timeout,
   output logic              err_overrun,
   output logic              busy
);

   localparam int unsigned TO_W       = $clog2(TIMEOUT);
   localparam logic [7:0]  DEST_LIMIT = 8'(N_DEST);

   rx_state_e        state_q, state_d;
   pkt_hdr_t         hdr_q, hdr_d;
   logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [7:0]       sum_q, sum_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             flush_q, flush_d;
   logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LEN_W-1:0] flush_len_q, flush_len_d;
   logic [7:0]       flush_dest_q, flush_dest_d;
   logic             wr_en, rd_en, timed_out;
   logic [N_DEST-1:0] valid_bus_d;
   logic [7:0]       src_addr_d;
   logic             pkt_ok_d, err_crc_d, err_addr_d, err_timeout_d, err_overrun_d, busy_d;

   pkt_buf u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (rx_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_q),
      .rd_data (master_data)
   );

   // Receive FSM, checksum, timeout and flush sequencing.
   always_comb begin
      state_d       = state_q;
      hdr_d         = hdr_q;
      wr_ptr_d      = wr_ptr_q;
      sum_d         = sum_q;
      to_cnt_d      = '0;
      flush_d       = flush_q;
      rd_ptr_d      = rd_ptr_q;
      flush_len_d   = flush_len_q;
      flush_dest_d  = flush_dest_q;
      wr_en         = 1'b0;
      rd_en         = flush_q;
      src_addr_d    = src_addr;
      pkt_ok_d      = 1'b0;
      err_crc_d     = 1'b0;
      err_addr_d    = 1'b0;
      err_timeout_d = 1'b0;
      err_overrun_d = 1'b0;

      if (flush_q) begin
         rd_ptr_d = rd_ptr_q + LEN_W'(1);
         if (rd_ptr_q == flush_len_q - LEN_W'(1)) flush_d = 1'b0;
      end

      if (!rx_valid && state_q != ST_IDLE) to_cnt_d = to_cnt_q + TO_W'(1);
      // Expiry fires as the counter steps onto TIMEOUT-1; a coincident byte wins.
      timed_out = (state_q != ST_IDLE) && !rx_valid && (to_cnt_q == TO_W'(TIMEOUT - 2));

      if (timed_out) begin
         state_d       = ST_IDLE;
         wr_ptr_d      = '0;
         sum_d         = '0;
         to_cnt_d      = '0;
         err_timeout_d = 1'b1;
      end else if (rx_valid) begin
         unique case (state_q)
            ST_IDLE: begin
               if (rx_data == PREFIX) begin
                  state_d  = ST_SRC;
                  wr_ptr_d = '0;
                  sum_d    = '0;
               end
            end
            ST_SRC: begin
               hdr_d.src = rx_data;
               state_d   = ST_DEST;
            end
            ST_DEST: begin
               hdr_d.dest = rx_data;
               state_d    = ST_LEN;
            end
            ST_LEN: begin
               hdr_d.len = rx_data;
               state_d   = (rx_data == 8'h00) ? ST_CRC : ST_DATA;
            end
            ST_DATA: begin
               if (flush_q) begin
                  err_overrun_d = 1'b1;
                  state_d       = ST_IDLE;
                  wr_ptr_d      = '0;
                  sum_d         = '0;
               end else begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + LEN_W'(1);
                  sum_d    = sum_q + rx_data;
                  if (wr_ptr_q == hdr_q.len - LEN_W'(1)) state_d = ST_CRC;
               end
            end
            ST_CRC: begin
               state_d = ST_IDLE;
               if (rx_data != sum_q) begin
                  err_crc_d = 1'b1;
               end else if (hdr_q.dest >= DEST_LIMIT) begin
                  err_addr_d = 1'b1;
               end else begin
                  pkt_ok_d   = 1'b1;
                  src_addr_d = hdr_q.src;
                  if (hdr_q.len != '0) begin
                     flush_d      = 1'b1;
                     rd_ptr_d     = '0;
                     flush_len_d  = hdr_q.len;
                     flush_dest_d = hdr_q.dest;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      valid_bus_d = rd_en ? (N_DEST'(1) << flush_dest_q) : '0;
      busy_d      = (state_d != ST_IDLE) || flush_d || rd_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         hdr_q        <= '0;
         wr_ptr_q     <= '0;
         sum_q        <= '0;
         to_cnt_q     <= '0;
         flush_q      <= 1'b0;
         rd_ptr_q     <= '0;
         flush_len_q  <= '0;
         flush_dest_q <= '0;
         valid_bus    <= '0;
         src_addr     <= '0;
         pkt_ok       <= 1'b0;
         err_crc      <= 1'b0;
         err_addr     <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_q        <= hdr_d;
         wr_ptr_q     <= wr_ptr_d;
         sum_q        <= sum_d;
         to_cnt_q     <= to_cnt_d;
         flush_q      <= flush_d;
         rd_ptr_q     <= rd_ptr_d;
         flush_len_q  <= flush_len_d;
         flush_dest_q <= flush_dest_d;
         valid_bus    <= valid_bus_d;
         src_addr     <= src_addr_d;
         pkt_ok       <= pkt_ok_d;
         err_crc      <= err_crc_d;
         err_addr     <= err_addr_d;
         err_timeout  <= err_timeout_d;
         err_overrun  <= err_overrun_d;
         busy         <= busy_d;
      end
   end

endmodule
